// File: rtl/id_ex_if.sv
// id_ex_if: bundles the ID inputs, downstream forwarding sources and EX outputs of id_ex_stage.
//   master : the surrounding pipeline side, which drives ID/forwarding inputs and reads EX outputs
//   slave  : the id_ex_stage side
interface id_ex_if #(parameter int XLEN = 32);
    logic            stall_i;
    logic            flush_i;
    logic [XLEN-1:0] RS1data_i;
    logic [XLEN-1:0] RS2data_i;
    logic [XLEN-1:0] imm_i;
    logic [4:0]      RS1addr_i;
    logic [4:0]      RS2addr_i;
    logic [4:0]      RDaddr_i;
    logic            ALUSrc_i;
    logic            RegWrite_i;
    logic            MemRead_i;
    logic            MemWrite_i;
    logic            MemtoReg_i;
    logic [2:0]      ALUCtrl_i;
    logic            EXMEM_RegWrite_i;
    logic            MEMWB_RegWrite_i;
    logic [4:0]      EXMEM_RDaddr_i;
    logic [4:0]      MEMWB_RDaddr_i;
    logic [XLEN-1:0] EXMEM_data_i;
    logic [XLEN-1:0] MEMWB_data_i;
    logic [XLEN-1:0] ALUdata1_o;
    logic [XLEN-1:0] ALUdata2_o;
    logic [2:0]      ALUCtrl_o;
    logic [XLEN-1:0] RS2fwd_o;
    logic [4:0]      RDaddr_o;
    logic            RegWrite_o;
    logic            MemRead_o;
    logic            MemWrite_o;
    logic            MemtoReg_o;
    logic            valid_o;
    logic            load_use_o;

    modport master (
        output stall_i, flush_i, RS1data_i, RS2data_i, imm_i, RS1addr_i, RS2addr_i, RDaddr_i,
               ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUCtrl_i,
               EXMEM_RegWrite_i, MEMWB_RegWrite_i, EXMEM_RDaddr_i, MEMWB_RDaddr_i,
               EXMEM_data_i, MEMWB_data_i,
        input  ALUdata1_o, ALUdata2_o, ALUCtrl_o, RS2fwd_o, RDaddr_o, RegWrite_o, MemRead_o,
               MemWrite_o, MemtoReg_o, valid_o, load_use_o
    );

    modport slave (
        input  stall_i, flush_i, RS1data_i, RS2data_i, imm_i, RS1addr_i, RS2addr_i, RDaddr_i,
               ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUCtrl_i,
               EXMEM_RegWrite_i, MEMWB_RegWrite_i, EXMEM_RDaddr_i, MEMWB_RDaddr_i,
               EXMEM_data_i, MEMWB_data_i,
        output ALUdata1_o, ALUdata2_o, ALUCtrl_o, RS2fwd_o, RDaddr_o, RegWrite_o, MemRead_o,
               MemWrite_o, MemtoReg_o, valid_o, load_use_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset, loads a bubble
//   bus   : id_ex_if slave -- ID fields, stall/flush, EX/MEM and MEM/WB forwarding sources in;
//           forwarded operands, registered controls, valid and load_use out
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input logic   clk_i,
    input logic   rst_i,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] rs1d;
        logic [XLEN-1:0] rs2d;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            alusrc;
        logic [2:0]      ctrl;
        logic            rw;
        logic            mr;
        logic            mw;
        logic            m2r;
        logic            v;
    } stage_t;

    stage_t          r_st;
    stage_t          w_id;
    logic            w_load_use;
    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;

    assign w_id = {bus.RS1data_i, bus.RS2data_i, bus.imm_i, bus.RS1addr_i, bus.RS2addr_i,
                   bus.RDaddr_i, bus.ALUSrc_i, bus.ALUCtrl_i, bus.RegWrite_i, bus.MemRead_i,
                   bus.MemWrite_i, bus.MemtoReg_i, 1'b1};

    // A bubble is all-zero, so it can never look like a load and raise a hazard.
    assign w_load_use = r_st.v && r_st.mr && r_st.rd != 5'd0 &&
                        (r_st.rd == bus.RS1addr_i || r_st.rd == bus.RS2addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_st <= '0;
        else if (bus.flush_i)
            r_st <= '0;
        else if (!bus.stall_i)
            r_st <= w_load_use ? '0 : w_id;
    end

    // EX/MEM is the younger producer, so it is checked first; x0 is never forwarded.
    always_comb begin
        w_src1 = (bus.EXMEM_RegWrite_i && bus.EXMEM_RDaddr_i != 5'd0 && bus.EXMEM_RDaddr_i == r_st.rs1) ? bus.EXMEM_data_i :
                 (bus.MEMWB_RegWrite_i && bus.MEMWB_RDaddr_i != 5'd0 && bus.MEMWB_RDaddr_i == r_st.rs1) ? bus.MEMWB_data_i :
                 r_st.rs1d;
        w_src2 = (bus.EXMEM_RegWrite_i && bus.EXMEM_RDaddr_i != 5'd0 && bus.EXMEM_RDaddr_i == r_st.rs2) ? bus.EXMEM_data_i :
                 (bus.MEMWB_RegWrite_i && bus.MEMWB_RDaddr_i != 5'd0 && bus.MEMWB_RDaddr_i == r_st.rs2) ? bus.MEMWB_data_i :
                 r_st.rs2d;
    end

    assign bus.ALUdata1_o = w_src1;
    assign bus.ALUdata2_o = r_st.alusrc ? r_st.imm : w_src2;
    assign bus.RS2fwd_o   = w_src2;
    assign bus.ALUCtrl_o  = r_st.ctrl;
    assign bus.RDaddr_o   = r_st.rd;
    assign bus.RegWrite_o = r_st.rw;
    assign bus.MemRead_o  = r_st.mr;
    assign bus.MemWrite_o = r_st.mw;
    assign bus.MemtoReg_o = r_st.m2r;
    assign bus.valid_o    = r_st.v;
    assign bus.load_use_o = w_load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against an instruction-level model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    id_ex_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d1, d2, imm;
        logic [4:0]  a1, a2, rd;
        logic        alusrc;
        logic [2:0]  ctrl;
        logic        rw, mr, mw, m2r, v;
    } instr_t;

    instr_t m;
    instr_t bubble;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] held);
        if (bus.EXMEM_RegWrite_i && bus.EXMEM_RDaddr_i != 0 && bus.EXMEM_RDaddr_i == a) return bus.EXMEM_data_i;
        if (bus.MEMWB_RegWrite_i && bus.MEMWB_RDaddr_i != 0 && bus.MEMWB_RDaddr_i == a) return bus.MEMWB_data_i;
        return held;
    endfunction

    function automatic logic exp_lu();
        return m.v && m.mr && m.rd != 0 && (m.rd == bus.RS1addr_i || m.rd == bus.RS2addr_i);
    endfunction

    task automatic check_all();
        logic [31:0] s2;
        s2 = fwd(m.a2, m.d2);
        chk("ALUdata1", bus.ALUdata1_o, fwd(m.a1, m.d1));
        chk("ALUdata2", bus.ALUdata2_o, m.alusrc ? m.imm : s2);
        chk("RS2fwd", bus.RS2fwd_o, s2);
        chk("ALUCtrl", 32'(bus.ALUCtrl_o), 32'(m.ctrl));
        chk("RDaddr", 32'(bus.RDaddr_o), 32'(m.rd));
        chk("RegWrite", 32'(bus.RegWrite_o), 32'(m.rw));
        chk("MemRead", 32'(bus.MemRead_o), 32'(m.mr));
        chk("MemWrite", 32'(bus.MemWrite_o), 32'(m.mw));
        chk("MemtoReg", 32'(bus.MemtoReg_o), 32'(m.m2r));
        chk("valid", 32'(bus.valid_o), 32'(m.v));
        chk("load_use", 32'(bus.load_use_o), 32'(exp_lu()));
    endtask

    // Advance one clock edge, updating the model by the flush > stall > load-use > capture rule.
    task automatic tick();
        instr_t nxt;
        if (bus.flush_i) nxt = bubble;
        else if (bus.stall_i) nxt = m;
        else if (exp_lu()) nxt = bubble;
        else begin
            nxt.d1 = bus.RS1data_i; nxt.d2 = bus.RS2data_i; nxt.imm = bus.imm_i;
            nxt.a1 = bus.RS1addr_i; nxt.a2 = bus.RS2addr_i; nxt.rd = bus.RDaddr_i;
            nxt.alusrc = bus.ALUSrc_i; nxt.ctrl = bus.ALUCtrl_i; nxt.rw = bus.RegWrite_i;
            nxt.mr = bus.MemRead_i; nxt.mw = bus.MemWrite_i; nxt.m2r = bus.MemtoReg_i; nxt.v = 1'b1;
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic set_id(input logic [4:0] a1, a2, rd, input logic [31:0] d1, d2, imm,
                          input logic alusrc, input logic [2:0] ctrl, input logic rw, mr, mw, m2r);
        bus.RS1addr_i = a1; bus.RS2addr_i = a2; bus.RDaddr_i = rd;
        bus.RS1data_i = d1; bus.RS2data_i = d2; bus.imm_i = imm;
        bus.ALUSrc_i = alusrc; bus.ALUCtrl_i = ctrl;
        bus.RegWrite_i = rw; bus.MemRead_i = mr; bus.MemWrite_i = mw; bus.MemtoReg_i = m2r;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] ed,
                           input logic mrw, input logic [4:0] mrd, input logic [31:0] md);
        bus.EXMEM_RegWrite_i = erw; bus.EXMEM_RDaddr_i = erd; bus.EXMEM_data_i = ed;
        bus.MEMWB_RegWrite_i = mrw; bus.MEMWB_RDaddr_i = mrd; bus.MEMWB_data_i = md;
    endtask

    initial begin
        logic [31:0] hold1, hold2;
        bubble = '{default: '0};
        m = bubble;
        bus.stall_i = 0; bus.flush_i = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_valid", 32'(bus.valid_o), 0);
        chk("reset_load_use", 32'(bus.load_use_o), 0);
        check_all();
        #4 rst = 0;
        // reset then capture: add x3 = x1 + x2
        set_id(1, 2, 3, 5, 7, 0, 0, 3'b010, 1, 0, 0, 0);
        tick();
        chk("add_ALUdata1", bus.ALUdata1_o, 5);
        chk("add_ALUdata2", bus.ALUdata2_o, 7);
        chk("add_RDaddr", 32'(bus.RDaddr_o), 3);
        chk("add_valid", 32'(bus.valid_o), 1);
        chk("add_ALUCtrl", 32'(bus.ALUCtrl_o), 2);
        check_all();
        // double forward on x4
        set_id(4, 2, 6, 32'h99, 1, 0, 0, 3'b000, 1, 0, 0, 0);
        tick();
        set_fwd(1, 4, 32'h11, 1, 4, 32'h22);
        #1 chk("dfwd_exmem", bus.ALUdata1_o, 32'h11);
        check_all();
        bus.EXMEM_RegWrite_i = 0;
        #1 chk("dfwd_memwb", bus.ALUdata1_o, 32'h22);
        check_all();
        // x0 guard
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 7, 3, 0, 0, 0, 3'b001, 1, 0, 0, 0);
        tick();
        set_fwd(1, 0, 32'hFFFF, 1, 0, 32'hEEEE);
        #1 chk("x0_RS2fwd", bus.RS2fwd_o, 0);
        check_all();
        set_fwd(0, 0, 0, 0, 0, 0);
        // load-use: lw x5 followed by a consumer of x5
        set_id(1, 0, 5, 32'h100, 0, 4, 1, 3'b010, 1, 1, 0, 1);
        tick();
        set_id(5, 6, 7, 32'hDEAD, 32'h6, 0, 0, 3'b010, 1, 0, 0, 0);
        #1 chk("lu_flag", 32'(bus.load_use_o), 1);
        check_all();
        tick();
        chk("lu_bubble_valid", 32'(bus.valid_o), 0);
        chk("lu_bubble_rw", 32'(bus.RegWrite_o), 0);
        chk("lu_bubble_mr", 32'(bus.MemRead_o), 0);
        chk("lu_cleared", 32'(bus.load_use_o), 0);
        check_all();
        set_fwd(0, 0, 0, 1, 5, 32'h55);
        tick();
        chk("lu_fwd_memwb", bus.ALUdata1_o, 32'h55);
        chk("lu_valid", 32'(bus.valid_o), 1);
        check_all();
        set_fwd(0, 0, 0, 0, 0, 0);
        // flush beats stall
        bus.flush_i = 1; bus.stall_i = 1;
        tick();
        chk("flush_valid", 32'(bus.valid_o), 0);
        check_all();
        bus.flush_i = 0; bus.stall_i = 0;
        set_id(2, 3, 8, 32'h10, 32'h20, 32'hFFFFFFFC, 1, 3'b010, 1, 0, 0, 0);
        tick();
        chk("imm_ALUdata2", bus.ALUdata2_o, 32'hFFFFFFFC);
        check_all();
        hold1 = bus.ALUdata1_o;
        hold2 = bus.ALUdata2_o;
        bus.stall_i = 1;
        set_id(9, 10, 11, 32'h1234, 32'h5678, 32'h1, 0, 3'b110, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ALUdata1", bus.ALUdata1_o, hold1);
            chk("stall_ALUdata2", bus.ALUdata2_o, 32'hFFFFFFFC);
            chk("stall_hold2", bus.ALUdata2_o, hold2);
            chk("stall_RDaddr", 32'(bus.RDaddr_o), 8);
            check_all();
        end
        bus.stall_i = 0;
        // asynchronous reset between edges
        set_id(1, 2, 12, 1, 2, 0, 0, 3'b011, 1, 0, 0, 0);
        tick();
        chk("pre_rst_valid", 32'(bus.valid_o), 1);
        #2 rst = 1;
        #1 m = bubble;
        chk("async_valid", 32'(bus.valid_o), 0);
        chk("async_rw", 32'(bus.RegWrite_o), 0);
        check_all();
        #1 rst = 0;
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            tick();
            bus.flush_i = ($urandom_range(9) == 0);
            bus.stall_i = ($urandom_range(5) == 0);
            bus.RS1addr_i = 5'($urandom_range(7));
            bus.RS2addr_i = 5'($urandom_range(7));
            bus.RDaddr_i = 5'($urandom_range(7));
            bus.RS1data_i = (bus.RS1addr_i == 0) ? 0 : $urandom;
            bus.RS2data_i = (bus.RS2addr_i == 0) ? 0 : $urandom;
            bus.imm_i = $urandom;
            bus.ALUSrc_i = 1'($urandom);
            bus.ALUCtrl_i = 3'($urandom);
            bus.RegWrite_i = 1'($urandom);
            bus.MemRead_i = ($urandom_range(2) == 0);
            bus.MemWrite_i = 1'($urandom);
            bus.MemtoReg_i = 1'($urandom);
            set_fwd(1'($urandom), 5'($urandom_range(7)), $urandom,
                    1'($urandom), 5'($urandom_range(7)), $urandom);
            #1 check_all();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width of operands, immediate and forwarded data.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 stall_i  input  1  hold all stage registers unchanged.
REQ-005 flush_i  input  1  load a bubble on next edge (branch taken).
REQ-006 RS1data_i, RS2data_i  input  XLEN  register-file read data from ID.
REQ-007 imm_i  input  XLEN  sign-extended immediate from ID.
REQ-008 RS1addr_i, RS2addr_i, RDaddr_i  input  5  source/destination register indices from ID.
REQ-009 ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i  input  1 each  ID control bits.
REQ-010 ALUCtrl_i  input  3  ALU operation code (000 and, 001 or, 010 add, 110 sub, 011 mul).
REQ-011 EXMEM_RegWrite_i, MEMWB_RegWrite_i  input  1 each  downstream write enables.
REQ-012 EXMEM_RDaddr_i, MEMWB_RDaddr_i  input  5 each  downstream destination indices.
REQ-013 EXMEM_data_i, MEMWB_data_i  input  XLEN each  downstream result values.
REQ-014 ALUdata1_o, ALUdata2_o  output  XLEN  forwarded ALU operands.
REQ-015 ALUCtrl_o  output  3  registered ALU operation code.
REQ-016 RS2fwd_o  output  XLEN  forwarded rs2 value (store data), before ALUSrc select.
REQ-017 RDaddr_o  output  5; RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o  output  1 each  registered controls.
REQ-018 valid_o  output  1  stage holds a real instruction (0 = bubble).
REQ-019 load_use_o  output  1  load-use hazard; upstream SHALL stall PC and IF/ID when high.

Function
REQ-020 Stage registers: RS1data, RS2data, imm, RS1addr, RS2addr, RDaddr, ALUSrc, ALUCtrl, RegWrite, MemRead, MemWrite, MemtoReg, valid.
REQ-021 Edge update priority: flush_i > stall_i > load_use_o > capture.
REQ-022 flush_i=1: load bubble regardless of stall_i.
REQ-023 stall_i=1 (no flush): all registers hold.
REQ-024 load_use_o=1 (no flush/stall): load bubble; ID inputs not consumed.
REQ-025 Otherwise capture all ID inputs, valid=1; latency ID->outputs exactly 1 cycle.
REQ-026 Bubble = all data/addr/control registers 0, valid=0.
REQ-027 load_use_o = valid & MemRead_o & RDaddr_o!=0 & (RDaddr_o==RS1addr_i | RDaddr_o==RS2addr_i); combinational.
REQ-028 Forward src1: EXMEM_data_i if EXMEM_RegWrite_i & EXMEM_RDaddr_i!=0 & EXMEM_RDaddr_i==RS1addr reg; else MEMWB_data_i under same rule with MEMWB; else RS1data reg.
REQ-029 Forward src2 to RS2fwd_o by identical rule on RS2addr reg; EX/MEM always wins over MEM/WB.
REQ-030 Register x0 never forwarded; reads of x0 yield registered value (0 from register file).
REQ-031 ALUdata1_o = forwarded src1; ALUdata2_o = imm reg if ALUSrc reg else RS2fwd_o.
REQ-032 Forwarding and operand select purely combinational on registered fields and current EXMEM/MEMWB inputs; no extra latency.
REQ-033 Bubble outputs: RegWrite_o=MemRead_o=MemWrite_o=0, so a bubble never writes state or triggers load_use_o.

Reset
REQ-034 rst_i=1 asynchronously forces all stage registers to bubble (REQ-026) without waiting for clk_i; load_use_o=0 while in reset.
REQ-035 Reset asserted mid-stall or mid-hazard discards the held instruction; first edge after release captures ID inputs per REQ-021.

Verification
REQ-036 Reset then capture: rst_i pulse, then add x3=x1+x2 with RS1data=5, RS2data=7, ALUCtrl=010 -> next cycle ALUdata1_o=5, ALUdata2_o=7, RDaddr_o=3, valid_o=1.
REQ-037 Double forward: stage holds rs1=x4; EXMEM writes x4=0x11, MEMWB writes x4=0x22 -> ALUdata1_o=0x11; drop EXMEM_RegWrite_i -> 0x22.
REQ-038 x0 guard: rs2=x0, EXMEM_RDaddr_i=0, EXMEM_RegWrite_i=1, data 0xFFFF -> RS2fwd_o=0.
REQ-039 Load-use: stage holds lw x5 (MemRead=1), ID presents rs1=x5 -> load_use_o=1; next edge valid_o=0, controls 0; following edge captures instruction, forwarding from MEMWB.
REQ-040 Priority: flush_i=1 with stall_i=1 -> bubble; stall_i=1 alone for 3 cycles -> all outputs constant; ALUSrc=1, imm=0xFFFFFFFC -> ALUdata2_o=0xFFFFFFFC.
REQ-041 Async reset: assert rst_i between edges while valid_o=1 -> valid_o and RegWrite_o fall immediately.
